mult_8x8_seq_ctrl: RTL and testbench

- Sequential 8x8 multiplier controller that time-shares one external 4x4 sub-multiplier to build a 16-bit product.
- Issues four nibble partial products (LL, LH, HL, HH) over successive cycles, shifts and accumulates them, and returns the result over a valid/ready handshake.
- A per-quadrant mode register selects which 4x4 variant (exact or approximate) the external unit applies to each partial product. This lets one unit realise any quadrant mix at runtime.

---
 rtl/mult_8x8_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_mult_8x8_seq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_8x8_seq_ctrl.sv
// rtl/mult_8x8_seq_ctrl.sv - 8x8 multiplier controller time-sharing one external 4x4 unit
// Runs four nibble partial products (LL, LH, HL, HH) through the unit and accumulates them.
module mult_8x8_seq_ctrl #(
  parameter logic [7:0] CFG_RESET = 8'h56,
  parameter int         SKIP_ZERO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_wdata,
  output logic [7:0]  cfg_q,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic [1:0]  mul_sel,
  input  logic [7:0]  mul_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_r,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [7:0]  mode_q;
  logic [15:0] acc;
  logic [1:0]  step;

  // Packs {nibble_a, nibble_b, sel} for step k in the fixed LL, LH, HL, HH order.
  function automatic logic [9:0] step_ops(input logic [1:0] k, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] m);
    logic [9:0] r;
    case (k)
      2'd0:    r = {a[3:0], b[3:0], m[1:0]};
      2'd1:    r = {a[3:0], b[7:4], m[3:2]};
      2'd2:    r = {a[7:4], b[3:0], m[5:4]};
      default: r = {a[7:4], b[7:4], m[7:6]};
    endcase
    return r;
  endfunction

  // Returns {found, index} of the lowest active step at or after start.
  function automatic logic [2:0] find_step(input logic [2:0] start, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [2:0] r;
    logic [9:0] ops;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      ops = step_ops(2'(k), a, b, 8'h00);
      if (3'(k) >= start && (SKIP_ZERO == 0 || (ops[9:6] != 4'h0 && ops[5:2] != 4'h0)))
        r = {1'b1, 2'(k)};
    end
    return r;
  endfunction

  logic [2:0]  first_step;
  logic [2:0]  next_step;
  logic [9:0]  first_ops;
  logic [9:0]  next_ops;
  logic [3:0]  shamt;
  logic [15:0] acc_sum;

  assign first_step = find_step(3'd0, in_a, in_b);
  assign first_ops  = step_ops(first_step[1:0], in_a, in_b, cfg_q);
  assign next_step  = find_step({1'b0, step} + 3'd1, a_q, b_q);
  assign next_ops   = step_ops(next_step[1:0], a_q, b_q, mode_q);
  assign shamt      = (step == 2'd0) ? 4'd0 : (step == 2'd3) ? 4'd8 : 4'd4;
  assign acc_sum    = acc + ({8'h00, mul_r} << shamt);

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cfg_q     <= CFG_RESET;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      mode_q    <= 8'h00;
      acc       <= 16'h0000;
      step      <= 2'd0;
      mul_a     <= 4'h0;
      mul_b     <= 4'h0;
      mul_sel   <= 2'd0;
      out_valid <= 1'b0;
      out_r     <= 16'h0000;
    end else begin
      if (cfg_we)
        cfg_q <= cfg_wdata;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= in_a;
            b_q    <= in_b;
            mode_q <= cfg_q;
            acc    <= 16'h0000;
            if (first_step[2]) begin
              state                   <= CALC;
              step                    <= first_step[1:0];
              {mul_a, mul_b, mul_sel} <= first_ops;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_r     <= 16'h0000;
            end
          end
        end
        CALC: begin
          acc <= acc_sum;
          if (next_step[2]) begin
            step                    <= next_step[1:0];
            {mul_a, mul_b, mul_sel} <= next_ops;
          end else begin
            state                   <= DONE;
            out_valid               <= 1'b1;
            out_r                   <= acc_sum;
            {mul_a, mul_b, mul_sel} <= 10'h000;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// tb/tb_mult_8x8_seq_ctrl.sv - self-checking bench for mult_8x8_seq_ctrl
// Instance 0 runs with SKIP_ZERO=0, instance 1 with SKIP_ZERO=1; both use an exact 4x4 model.
module tb_mult_8x8_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_we_v    [2];
  logic [7:0]  cfg_wdata_v [2];
  logic [7:0]  cfg_q_v     [2];
  logic        in_valid_v  [2];
  logic        in_ready_v  [2];
  logic [7:0]  in_a_v      [2];
  logic [7:0]  in_b_v      [2];
  logic [3:0]  mul_a_v     [2];
  logic [3:0]  mul_b_v     [2];
  logic [1:0]  mul_sel_v   [2];
  logic [7:0]  mul_r_v     [2];
  logic        out_valid_v [2];
  logic        out_ready_v [2];
  logic [15:0] out_r_v     [2];
  logic        busy_v      [2];

  mult_8x8_seq_ctrl #(.CFG_RESET(8'h56), .SKIP_ZERO(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we_v[0]), .cfg_wdata(cfg_wdata_v[0]),
    .cfg_q(cfg_q_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_a(in_a_v[0]), .in_b(in_b_v[0]), .mul_a(mul_a_v[0]), .mul_b(mul_b_v[0]),
    .mul_sel(mul_sel_v[0]), .mul_r(mul_r_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .out_r(out_r_v[0]), .busy(busy_v[0])
  );

  mult_8x8_seq_ctrl #(.CFG_RESET(8'h56), .SKIP_ZERO(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we_v[1]), .cfg_wdata(cfg_wdata_v[1]),
    .cfg_q(cfg_q_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_a(in_a_v[1]), .in_b(in_b_v[1]), .mul_a(mul_a_v[1]), .mul_b(mul_b_v[1]),
    .mul_sel(mul_sel_v[1]), .mul_r(mul_r_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .out_r(out_r_v[1]), .busy(busy_v[1])
  );

  assign mul_r_v[0] = {4'h0, mul_a_v[0]} * {4'h0, mul_b_v[0]};
  assign mul_r_v[1] = {4'h0, mul_a_v[1]} * {4'h0, mul_b_v[1]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cur = 0;
  int results = 0;
  int acc_c = 0;
  int valid_cyc = 0;
  bit seen_valid = 0;
  logic [15:0] exp_q [$];
  logic [9:0]  op_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: logs each CALC cycle's unit drive and scores results at handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_v[cur] && !out_valid_v[cur])
        op_log.push_back({mul_a_v[cur], mul_b_v[cur], mul_sel_v[cur]});
      if (out_valid_v[cur] && !seen_valid) begin
        seen_valid = 1;
        valid_cyc  = cyc;
      end
      if (out_valid_v[cur] && out_ready_v[cur]) begin
        if (exp_q.size() == 0)
          check("unexpected_result", 32'd1, 32'd0);
        else
          check("out_r", {16'h0, out_r_v[cur]}, {16'h0, exp_q.pop_front()});
        results++;
      end
    end
  end

  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] r, input logic [7:0] mode,
                        input logic cfg_w, input logic [7:0] cfg_wd);
    logic [9:0] eops [$];
    logic [1:0] kk;
    logic [3:0] na;
    logic [3:0] nb;
    int res0;
    bit got;
    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      na = kk[1] ? a[7:4] : a[3:0];
      nb = kk[0] ? b[7:4] : b[3:0];
      if (d == 0 || (na != 4'h0 && nb != 4'h0))
        eops.push_back({na, nb, mode[2*k +: 2]});
    end
    cur = d;
    op_log.delete();
    seen_valid = 0;
    res0 = results;
    out_ready_v[d] = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready_v[d]) begin
        got = 1;
        break;
      end
      tick();
    end
    check("in_ready_before_op", {31'h0, got}, 32'd1);
    in_valid_v[d] = 1'b1;
    in_a_v[d] = a;
    in_b_v[d] = b;
    cfg_we_v[d] = cfg_w;
    cfg_wdata_v[d] = cfg_wd;
    exp_q.push_back(r);
    tick();
    acc_c = cyc;
    in_valid_v[d] = 1'b0;
    cfg_we_v[d] = 1'b0;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      if (results != res0) begin
        got = 1;
        break;
      end
      tick();
    end
    check("result_arrived", {31'h0, got}, 32'd1);
    check("post_out_valid", {31'h0, out_valid_v[d]}, 32'd0);
    check("post_in_ready", {31'h0, in_ready_v[d]}, 32'd1);
    check("post_out_r_hold", {16'h0, out_r_v[d]}, {16'h0, r});
    check("latency", valid_cyc - acc_c, eops.size());
    check("calc_cycles", op_log.size(), eops.size());
    for (int i = 0; i < eops.size() && i < op_log.size(); i++)
      check("step_drive", {22'h0, op_log[i]}, {22'h0, eops[i]});
  endtask

  typedef struct {
    int          d;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int res0;
    bit got;
    vecs[0]  = '{0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1]  = '{0, 8'h00, 8'h00, 16'h0000};
    vecs[2]  = '{0, 8'h12, 8'h34, 16'h03A8};
    vecs[3]  = '{0, 8'h80, 8'h01, 16'h0080};
    vecs[4]  = '{0, 8'hA5, 8'h5A, 16'h3A02};
    vecs[5]  = '{0, 8'h01, 8'h10, 16'h0010};
    vecs[6]  = '{1, 8'h0F, 8'hF0, 16'h0E10};
    vecs[7]  = '{1, 8'h00, 8'h37, 16'h0000};
    vecs[8]  = '{1, 8'hFF, 8'hFF, 16'hFE01};
    vecs[9]  = '{1, 8'h10, 8'h01, 16'h0010};
    vecs[10] = '{1, 8'h11, 8'h11, 16'h0121};
    vecs[11] = '{1, 8'h20, 8'h02, 16'h0040};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cfg_we_v[d] = 1'b0;
      cfg_wdata_v[d] = 8'h00;
      in_valid_v[d] = 1'b0;
      in_a_v[d] = 8'h00;
      in_b_v[d] = 8'h00;
      out_ready_v[d] = 1'b1;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_cfg_q", {24'h0, cfg_q_v[d]}, 32'h56);
      check("rst_in_ready", {31'h0, in_ready_v[d]}, 32'd1);
      check("rst_out_valid", {31'h0, out_valid_v[d]}, 32'd0);
      check("rst_out_r", {16'h0, out_r_v[d]}, 32'h0);
      check("rst_busy", {31'h0, busy_v[d]}, 32'd0);
      check("rst_mul_sel", {30'h0, mul_sel_v[d]}, 32'd0);
    end

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].r, 8'h56, 1'b0, 8'h00);

    // Backpressure: result held while a new operand waits on in_valid.
    cur = 0;
    op_log.delete();
    seen_valid = 0;
    out_ready_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    in_a_v[0] = 8'h12;
    in_b_v[0] = 8'h34;
    exp_q.push_back(16'h03A8);
    tick();
    in_a_v[0] = 8'h56;
    in_b_v[0] = 8'h78;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid_v[0]) begin
        got = 1;
        break;
      end
      tick();
    end
    check("bp_valid_arrived", {31'h0, got}, 32'd1);
    repeat (3) begin
      check("bp_out_r", {16'h0, out_r_v[0]}, 32'h03A8);
      check("bp_out_valid", {31'h0, out_valid_v[0]}, 32'd1);
      check("bp_in_ready", {31'h0, in_ready_v[0]}, 32'd0);
      tick();
    end
    res0 = results;
    out_ready_v[0] = 1'b1;
    exp_q.push_back(16'h2850);
    tick();
    check("bp_first_result", results - res0, 32'd1);
    check("bp_idle_after_hs", {31'h0, in_ready_v[0]}, 32'd1);
    tick();
    in_valid_v[0] = 1'b0;
    check("bp_second_accepted", {31'h0, in_ready_v[0]}, 32'd0);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (results - res0 == 2) begin
        got = 1;
        break;
      end
      tick();
    end
    check("bp_second_result", {31'h0, got}, 32'd1);

    // Config write on the accept edge applies only from the next operation.
    run_op(0, 8'h21, 8'h43, 16'h08A3, 8'h56, 1'b1, 8'h00);
    check("cfg_q_written", {24'h0, cfg_q_v[0]}, 32'h00);
    run_op(0, 8'h12, 8'h34, 16'h03A8, 8'h00, 1'b0, 8'h00);

    // Reset in the second CALC cycle drops the operation.
    cur = 0;
    op_log.delete();
    seen_valid = 0;
    res0 = results;
    out_ready_v[0] = 1'b1;
    in_valid_v[0] = 1'b1;
    in_a_v[0] = 8'hAB;
    in_b_v[0] = 8'hCD;
    tick();
    in_valid_v[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'h0, out_valid_v[0]}, 32'd0);
    check("mid_rst_busy", {31'h0, busy_v[0]}, 32'd0);
    check("mid_rst_in_ready", {31'h0, in_ready_v[0]}, 32'd1);
    check("mid_rst_mul", {22'h0, mul_a_v[0], mul_b_v[0], mul_sel_v[0]}, 32'h0);
    check("mid_rst_out_r", {16'h0, out_r_v[0]}, 32'h0);
    check("mid_rst_cfg_q", {24'h0, cfg_q_v[0]}, 32'h56);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("mid_rst_no_valid", {31'h0, seen_valid}, 32'd0);
    check("mid_rst_no_result", results - res0, 32'd0);
    run_op(0, 8'h02, 8'h03, 16'h0006, 8'h56, 1'b0, 8'h00);
    check("after_rst_out_r", {16'h0, out_r_v[0]}, 32'h0006);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
